// File: rtl/div_pkg.sv
// Shared types for the divide requester: operation encoding, FSM states and op decode helpers.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } div_state_t;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/unsigned_division_interface.sv
// Handshake between the requester and an unsigned divider core.
// start is a one-cycle pulse; done may arrive in the start cycle or any later cycle.
interface unsigned_division_interface #(
    parameter int DATA_WIDTH = 32
);
    localparam int CLZ_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic [CLZ_W-1:0]      dividend_CLZ;
    logic [CLZ_W-1:0]      divisor_CLZ;
    logic                  start;
    logic [DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0] remainder;
    logic                  done;

    modport requester (
        output dividend, divisor, dividend_CLZ, divisor_CLZ, start,
        input  quotient, remainder, done
    );

    modport divider (
        input  dividend, divisor, dividend_CLZ, divisor_CLZ, start,
        output quotient, remainder, done
    );
endinterface

// File: rtl/div_clz.sv
// Leading-zero counter; combinational, no backpressure.
// A zero input reports W-1 so the result always fits in $clog2(W) bits.
module div_clz #(
    parameter int W  = 32,
    parameter int CW = $clog2(W)
) (
    input  logic [W-1:0]  val,
    output logic [CW-1:0] clz
);

    // Ascending scan: the highest set bit is the last one to write clz.
    always_comb begin
        clz = CW'(W - 1);
        for (int i = 0; i < W; i++) begin
            if (val[i]) begin
                clz = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_requester.sv
// Signed/unsigned divide front-end around an unsigned core; result one cycle after done (div-by-zero: one cycle after accept).
// One operation outstanding: req_ready only in IDLE, response held until rsp_ready, flush discards.
module div_requester
    import div_pkg::*;
#(
    parameter int DIV_WIDTH = 32,
    parameter int ID_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  div_op_t              req_op,
    input  logic [DIV_WIDTH-1:0] req_rs1,
    input  logic [DIV_WIDTH-1:0] req_rs2,
    input  logic [ID_W-1:0]      req_id,
    input  logic                 flush,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DIV_WIDTH-1:0] rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    unsigned_division_interface.requester div
);

    localparam int CLZ_W = $clog2(DIV_WIDTH);

    div_state_t           state, state_nxt;
    logic [DIV_WIDTH-1:0] mag1, mag2;
    logic                 neg1, neg2;
    div_op_t              op_q;
    logic                 start_q;
    logic                 discard;

    logic                 accept;
    logic                 rs2_zero;
    logic                 rs1_neg, rs2_neg;
    logic [DIV_WIDTH-1:0] rs1_mag, rs2_mag;
    logic [DIV_WIDTH-1:0] dbz_res, core_res;
    logic [CLZ_W-1:0]     clz1, clz2;

    assign req_ready = (state == IDLE) && !flush;
    assign accept    = req_ready && req_valid;
    assign rs2_zero  = (req_rs2 == '0);
    assign rs1_neg   = op_is_signed(req_op) && req_rs1[DIV_WIDTH-1];
    assign rs2_neg   = op_is_signed(req_op) && req_rs2[DIV_WIDTH-1];
    assign rs1_mag   = rs1_neg ? -req_rs1 : req_rs1;
    assign rs2_mag   = rs2_neg ? -req_rs2 : req_rs2;
    assign dbz_res   = op_is_rem(req_op) ? req_rs1 : '1;

    // neg flags already fold in signedness, so unsigned ops never get corrected.
    assign core_res  = op_is_rem(op_q)
                     ? (neg1 ? -div.remainder : div.remainder)
                     : ((neg1 ^ neg2) ? -div.quotient : div.quotient);

    div_clz #(.W(DIV_WIDTH), .CW(CLZ_W)) u_clz_dividend (.val(mag1), .clz(clz1));
    div_clz #(.W(DIV_WIDTH), .CW(CLZ_W)) u_clz_divisor  (.val(mag2), .clz(clz2));

    assign div.dividend     = mag1;
    assign div.divisor      = mag2;
    assign div.dividend_CLZ = clz1;
    assign div.divisor_CLZ  = clz2;
    assign div.start        = start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)             state_nxt = rs2_zero ? RESP : WAIT;
            WAIT: if (div.done)           state_nxt = (discard || flush) ? IDLE : RESP;
            RESP: if (flush || rsp_ready) state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag1      <= '0;
            mag2      <= '0;
            neg1      <= 1'b0;
            neg2      <= 1'b0;
            op_q      <= DIVU;
            start_q   <= 1'b0;
            discard   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            start_q <= 1'b0;
            if (accept) begin
                mag1    <= rs1_mag;
                mag2    <= rs2_mag;
                neg1    <= rs1_neg;
                neg2    <= rs2_neg;
                op_q    <= req_op;
                rsp_id  <= req_id;
                start_q <= !rs2_zero;
                if (rs2_zero) begin
                    rsp_data  <= dbz_res;
                    rsp_valid <= 1'b1;
                end
            end
            // A flushed operation still runs to done so the core is never restarted mid-flight.
            if (state == WAIT) begin
                if (div.done) begin
                    discard <= 1'b0;
                    if (!discard && !flush) begin
                        rsp_data  <= core_res;
                        rsp_valid <= 1'b1;
                    end
                end else if (flush) begin
                    discard <= 1'b1;
                end
            end
            if (state == RESP && (flush || rsp_ready)) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/div_requester.md
DIV_REQUESTER -- requirements
Module: div_requester

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 32, operand and result width.
REQ-002 SHALL have parameter ID_W, default 4, width of the transaction tag.
REQ-003 SHALL have port clk  input  1  clock; one clock, all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-007 SHALL have port req_op  input  2  div_op_t: DIV, DIVU, REM, REMU.
REQ-008 SHALL have port req_rs1  input  DIV_WIDTH  dividend.
REQ-009 SHALL have port req_rs2  input  DIV_WIDTH  divisor.
REQ-010 SHALL have port req_id  input  ID_W  tag, returned unchanged.
REQ-011 SHALL have port flush  input  1  discards the in-flight and held operation.
REQ-012 SHALL have port rsp_valid  output  1  result present.
REQ-013 SHALL have port rsp_ready  input  1  result consumed when high with rsp_valid.
REQ-014 SHALL have port rsp_data  output  DIV_WIDTH  quotient or remainder.
REQ-015 SHALL have port rsp_id  output  ID_W  tag of the result.
REQ-016 SHALL have port div  unsigned_division_interface requester modport.
- Drives: dividend, divisor, dividend_CLZ, divisor_CLZ, start.
- Samples: quotient, remainder, done.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 SHALL assert req_ready only in IDLE when flush is low.
REQ-019 SHALL, on acceptance, register the following, then transition:
- |rs1| and |rs2|: two's-complement magnitude for DIV/REM, raw for DIVU/REMU.
- Both operand signs, op, id.
- Divide-by-zero flag (rs2==0).
- Transition to WAIT, or to RESP when divide-by-zero.
REQ-020 SHALL pulse div.start for exactly one cycle, the first WAIT cycle; dividend/divisor/CLZ values SHALL be stable throughout WAIT.
REQ-021 SHALL drive CLZ values combinationally from the registered magnitudes, width $clog2(DIV_WIDTH); CLZ of zero SHALL be DIV_WIDTH-1.
REQ-022 SHALL accept div.done in the start cycle itself (divisor larger than dividend) or in any later WAIT cycle.
REQ-023 SHALL, on done, latch the result, move to RESP, and assert rsp_valid the following cycle.
- Latched result: quotient for DIV/DIVU, remainder for REM/REMU.
REQ-024 SHALL negate the quotient for signed ops when the operand signs differ.
REQ-025 SHALL negate the remainder for signed ops when the dividend is negative.
REQ-026 SHALL, on divide-by-zero, bypass the core (no start) and assert rsp_valid one cycle after acceptance.
- Quotient SHALL be all ones; remainder SHALL be the original rs1.
- No sign correction SHALL be applied.
REQ-027 SHALL produce signed overflow (most-negative / -1) as quotient = most-negative, remainder = 0, with no special path.
REQ-028 SHALL hold rsp_valid, rsp_data and rsp_id stable until rsp_ready; on the handshake cycle it SHALL return to IDLE.
REQ-029 SHALL handle flush in WAIT by setting a discard flag and remaining in WAIT until done; it SHALL then return to IDLE with no response.
REQ-030 SHALL handle flush in RESP by deasserting rsp_valid the next cycle and returning to IDLE.
REQ-031 SHALL give flush priority over a simultaneous req_valid or rsp_ready.
REQ-032 SHALL never pulse start while the core is running (one operation outstanding).

Reset
REQ-033 SHALL, when rst_n is low, asynchronously force the following:
- FSM to IDLE.
- rsp_valid, div.start and the discard flag to 0.
- rsp_data and rsp_id to 0.
REQ-034 SHALL, on a reset asserted mid-operation, abandon the operation, since the core is reset concurrently; the first post-reset request SHALL behave normally.

Structure
REQ-035 SHALL take div_op_t and the FSM state type from shared package div_pkg.
REQ-036 SHALL instantiate a single sub-module, div_clz (parameterized leading-zero counter), twice: once for the dividend and once for the divisor.

Verification
REQ-037 SHALL cover DIVU 100/7 -> rsp_data 14; REMU 100/7 -> 2.
REQ-038 SHALL cover DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-039 SHALL cover the following division-by-zero and overflow cases:
- DIV 5/0 -> 0xFFFFFFFF one cycle after acceptance, no start.
- REM 0x80000000/0 -> 0x80000000.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-040 SHALL cover DIVU 3/10 -> done in the start cycle, rsp_data 0; REMU -> 3.
REQ-041 SHALL cover flush two cycles after start -> no rsp_valid; req_ready high the cycle after done; next request DIVU 9/3 -> 3.
REQ-042 SHALL cover rsp_ready held low 5 cycles -> rsp_valid, rsp_data and rsp_id stable; req_ready low until the handshake.
